pgr_apb_burst_mif: RTL and testbench

Parametrised APB master engine that executes multi-beat burst commands. Each command carries direction, start address, beat count and byte strobe. Write data arrives on a DW-wide valid/ready stream; read data leaves on a valid/ready stream with back-pressure. Each APB access has a timeout watchdog, and every command ends with one done/status pulse. It sits between the UART command parser and the APB fabric, and replaces the single-beat master interface.

---
 rtl/pgr_apb_burst_mif.sv | 203 ++++++++++++++++++++
 tb/tb_pgr_apb_burst_mif.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pgr_apb_burst_mif.sv
`default_nettype none
// ============================================================================
// Module   : pgr_apb_burst_mif
// Brief    : APB master engine executing multi-beat burst commands with
//            streamed write/read data, per-access timeout and done status.
// Revision : 1.0
// ============================================================================
module pgr_apb_burst_mif #(
    parameter int AW       = 16,
    parameter int DW       = 32,
    parameter int SW       = DW / 8,
    parameter int LW       = 8,
    parameter int ADDR_INC = DW / 8,
    parameter int TO_CYC   = 1024
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_we,
    input  logic [AW-1:0] cmd_addr,
    input  logic [LW-1:0] cmd_len,
    input  logic [SW-1:0] cmd_strb,
    input  logic          wd_valid,
    output logic          wd_ready,
    input  logic [DW-1:0] wd_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic          p_sel,
    output logic          p_ce,
    output logic          p_we,
    output logic [AW-1:0] p_addr,
    output logic [DW-1:0] p_wdata,
    output logic [SW-1:0] p_strb,
    input  logic          p_rdy,
    input  logic [DW-1:0] p_rdata,
    output logic          done,
    output logic          done_err,
    output logic [LW:0]   done_cnt,
    output logic          busy
);

    localparam int TW = $clog2(TO_CYC);
    localparam logic [TW-1:0] C_TO_LAST  = TW'(TO_CYC - 1);
    localparam logic [TW-1:0] C_TO_ONE   = TW'(1);
    localparam logic [LW:0]   C_CNT_ONE  = (LW+1)'(1);
    localparam logic [AW-1:0] C_ADDR_INC = AW'(ADDR_INC);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WDATA  = 3'd1,
        S_SETUP  = 3'd2,
        S_ACCESS = 3'd3,
        S_RPUSH  = 3'd4,
        S_FIN    = 3'd5
    } state_t;

    state_t          r_state;
    logic            r_we;
    logic [AW-1:0]   r_addr;
    logic [LW:0]     r_beats;
    logic [LW:0]     r_cnt;
    logic [TW-1:0]   r_to_cnt;

    logic            w_last_beat;
    logic            w_timeout;

    // Evaluated in ACCESS before the completed count is bumped.
    assign w_last_beat = ((r_cnt + C_CNT_ONE) == r_beats);
    assign w_timeout   = (r_to_cnt == C_TO_LAST);
    assign p_addr      = r_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_beats   <= '0;
            r_cnt     <= '0;
            r_to_cnt  <= '0;
            cmd_ready <= 1'b1;
            wd_ready  <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            p_sel     <= 1'b0;
            p_ce      <= 1'b0;
            p_we      <= 1'b0;
            p_wdata   <= '0;
            p_strb    <= '0;
            done      <= 1'b0;
            done_err  <= 1'b0;
            done_cnt  <= '0;
            busy      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_we      <= cmd_we;
                        p_we      <= cmd_we;
                        r_addr    <= cmd_addr;
                        p_strb    <= cmd_we ? cmd_strb : '1;
                        r_beats   <= {1'b0, cmd_len} + C_CNT_ONE;
                        r_cnt     <= '0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (cmd_we) begin
                            wd_ready <= 1'b1;
                            r_state  <= S_WDATA;
                        end else begin
                            p_sel    <= 1'b1;
                            r_to_cnt <= '0;
                            r_state  <= S_SETUP;
                        end
                    end
                end

                S_WDATA: begin
                    if (wd_valid) begin
                        p_wdata  <= wd_data;
                        wd_ready <= 1'b0;
                        p_sel    <= 1'b1;
                        r_to_cnt <= '0;
                        r_state  <= S_SETUP;
                    end
                end

                S_SETUP: begin
                    p_ce    <= 1'b1;
                    r_state <= S_ACCESS;
                end

                S_ACCESS: begin
                    // A ready on the final watchdog cycle still completes the beat.
                    if (p_rdy) begin
                        p_sel  <= 1'b0;
                        p_ce   <= 1'b0;
                        r_cnt  <= r_cnt + C_CNT_ONE;
                        r_addr <= r_addr + C_ADDR_INC;
                        if (!r_we) begin
                            rd_data  <= p_rdata;
                            rd_valid <= 1'b1;
                            r_state  <= S_RPUSH;
                        end else if (w_last_beat) begin
                            done     <= 1'b1;
                            done_err <= 1'b0;
                            done_cnt <= r_cnt + C_CNT_ONE;
                            r_state  <= S_FIN;
                        end else begin
                            wd_ready <= 1'b1;
                            r_state  <= S_WDATA;
                        end
                    end else if (w_timeout) begin
                        p_sel    <= 1'b0;
                        p_ce     <= 1'b0;
                        done     <= 1'b1;
                        done_err <= 1'b1;
                        done_cnt <= r_cnt;
                        r_state  <= S_FIN;
                    end else begin
                        r_to_cnt <= r_to_cnt + C_TO_ONE;
                    end
                end

                S_RPUSH: begin
                    if (rd_ready) begin
                        rd_valid <= 1'b0;
                        if (r_cnt == r_beats) begin
                            done     <= 1'b1;
                            done_err <= 1'b0;
                            done_cnt <= r_cnt;
                            r_state  <= S_FIN;
                        end else begin
                            p_sel    <= 1'b1;
                            r_to_cnt <= '0;
                            r_state  <= S_SETUP;
                        end
                    end
                end

                S_FIN: begin
                    done_err  <= 1'b0;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    r_state   <= S_IDLE;
                end

                default: begin
                    p_sel     <= 1'b0;
                    p_ce      <= 1'b0;
                    wd_ready  <= 1'b0;
                    rd_valid  <= 1'b0;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pgr_apb_burst_mif.sv
`default_nettype none
// ============================================================================
// Module   : tb_pgr_apb_burst_mif
// Brief    : Directed self-checking bench for pgr_apb_burst_mif.
// Revision : 1.0
// ============================================================================
module tb_pgr_apb_burst_mif;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_we = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic [3:0]  cmd_strb = '0;
    logic        wd_valid = 1'b0;
    logic [31:0] wd_data = '0;
    logic        rd_ready = 1'b0;
    logic        p_rdy = 1'b0;
    logic [31:0] p_rdata = '0;

    logic        cmd_ready, wd_ready, rd_valid, p_sel, p_ce, p_we, done, done_err, busy;
    logic [31:0] rd_data, p_wdata;
    logic [15:0] p_addr;
    logic [3:0]  p_strb;
    logic [8:0]  done_cnt;

    logic        cmd_ready1, wd_ready1, rd_valid1, p_sel1, p_ce1, p_we1, done1, done_err1, busy1;
    logic [31:0] rd_data1, p_wdata1;
    logic [15:0] p_addr1;
    logic [3:0]  p_strb1;
    logic [8:0]  done_cnt1;

    pgr_apb_burst_mif #(.AW(16), .DW(32), .LW(8), .ADDR_INC(4), .TO_CYC(16)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_strb(cmd_strb),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .p_sel(p_sel), .p_ce(p_ce), .p_we(p_we), .p_addr(p_addr),
        .p_wdata(p_wdata), .p_strb(p_strb), .p_rdy(p_rdy), .p_rdata(p_rdata),
        .done(done), .done_err(done_err), .done_cnt(done_cnt), .busy(busy)
    );

    pgr_apb_burst_mif #(.AW(16), .DW(32), .LW(8), .ADDR_INC(0), .TO_CYC(16)) u_dut_fixed (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready1), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_strb(cmd_strb),
        .wd_valid(wd_valid), .wd_ready(wd_ready1), .wd_data(wd_data),
        .rd_valid(rd_valid1), .rd_ready(rd_ready), .rd_data(rd_data1),
        .p_sel(p_sel1), .p_ce(p_ce1), .p_we(p_we1), .p_addr(p_addr1),
        .p_wdata(p_wdata1), .p_strb(p_strb1), .p_rdy(p_rdy), .p_rdata(p_rdata),
        .done(done1), .done_err(done_err1), .done_cnt(done_cnt1), .busy(busy1)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // APB responder / stream source configuration
    int          wait_n = 0;
    int          hang_beat = -1;
    int          acc_cnt = 0;
    int          beat_idx = 0;
    logic [31:0] rd_base = 32'h11;
    logic [31:0] rd_step = 32'h11;
    logic        wd_en = 1'b0;
    int          wd_idx = 0;
    logic [31:0] wd_tab [0:3];

    logic [15:0] log_addr[$];
    logic [15:0] log_addr1[$];
    logic        log_we[$];
    logic [31:0] log_wdata[$];
    logic [3:0]  log_strb[$];
    logic [31:0] rd_log[$];

    // Monitor state
    int          cyc = 0;
    int          acc_cyc = 0;
    int          done_cyc = 0;
    int          done_seen = 0;
    logic        d_err = 1'b0;
    logic [8:0]  d_cnt = '0;
    int          setup_cnt = 0;
    int          run = 0;
    int          last_run = 0;
    int          sel_stall = 0;
    int          unstable = 0;
    logic        stall_prev = 1'b0;
    logic [31:0] stall_data = '0;

    always @(negedge clk) begin
        if (p_sel && p_ce) begin
            acc_cnt = acc_cnt + 1;
            if (acc_cnt > wait_n && beat_idx != hang_beat) begin
                p_rdy   = 1'b1;
                p_rdata = rd_base + rd_step * beat_idx;
                log_addr.push_back(p_addr);
                log_addr1.push_back(p_addr1);
                log_we.push_back(p_we);
                log_wdata.push_back(p_wdata);
                log_strb.push_back(p_strb);
                beat_idx = beat_idx + 1;
            end else begin
                p_rdy = 1'b0;
            end
        end else begin
            acc_cnt = 0;
            p_rdy   = 1'b0;
        end
        wd_valid = wd_en;
        wd_data  = (wd_idx < 4) ? wd_tab[wd_idx] : 32'h0;
    end

    always @(posedge clk) begin
        if (cmd_valid && cmd_ready) acc_cyc = cyc;
        if (done) begin
            done_seen = done_seen + 1;
            d_err     = done_err;
            d_cnt     = done_cnt;
            done_cyc  = cyc;
        end
        if (rd_valid && rd_ready) rd_log.push_back(rd_data);
        if (wd_valid && wd_ready) wd_idx = wd_idx + 1;
        if (p_sel && !p_ce) setup_cnt = setup_cnt + 1;
        if (p_ce) run = run + 1;
        else if (run != 0) begin
            last_run = run;
            run = 0;
        end
        if (rd_valid && !rd_ready) begin
            if (stall_prev && rd_data !== stall_data) unstable = unstable + 1;
            if (p_sel) sel_stall = sel_stall + 1;
            stall_prev = 1'b1;
            stall_data = rd_data;
        end else begin
            stall_prev = 1'b0;
        end
        cyc = cyc + 1;
    end

    task automatic clear_logs();
        log_addr.delete(); log_addr1.delete(); log_we.delete();
        log_wdata.delete(); log_strb.delete(); rd_log.delete();
        beat_idx = 0; setup_cnt = 0; sel_stall = 0; unstable = 0; last_run = 0;
    endtask

    task automatic issue(input logic we, input logic [15:0] a, input logic [7:0] len,
                         input logic [3:0] s);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = a; cmd_len = len; cmd_strb = s;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string name, input int maxc);
        int start;
        start = done_seen;
        for (int i = 0; i < maxc && done_seen == start; i++) begin
            @(posedge clk); #1;
        end
        if (done_seen == start) begin
            $display("FAIL %s_done_timeout: got no done within %0d cycles, want done", name, maxc);
            n_fail++;
        end
        n_cmp++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        if (cmd_ready !== 1'b1 || cmd_ready1 !== 1'b1) begin
            $display("FAIL reset_cmd_ready: got %b/%b want 1/1", cmd_ready, cmd_ready1); n_fail++;
        end
        n_cmp++;
        if ({busy, done, done_err, wd_ready, rd_valid, p_sel, p_ce, p_we} !== 8'h00) begin
            $display("FAIL reset_ctrl: got %b want 00000000",
                     {busy, done, done_err, wd_ready, rd_valid, p_sel, p_ce, p_we}); n_fail++;
        end
        n_cmp++;
        if (done_cnt !== 9'd0 || p_strb !== 4'h0 || p_addr !== 16'h0 || rd_data !== 32'h0) begin
            $display("FAIL reset_data: got cnt=%h strb=%h addr=%h rd=%h want zeros",
                     done_cnt, p_strb, p_addr, rd_data); n_fail++;
        end
        n_cmp++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_burst();
        clear_logs();
        wd_tab[0] = 32'hA0; wd_tab[1] = 32'hA1; wd_tab[2] = 32'hA2; wd_tab[3] = 32'hA3;
        wd_idx = 0; wait_n = 0; rd_ready = 1'b1; wd_en = 1'b1;
        issue(1'b1, 16'h0010, 8'd3, 4'hF);
        wait_done("wr", 100);
        wd_en = 1'b0;
        if (log_addr.size() !== 4) begin
            $display("FAIL wr_beats: got %0d want 4", log_addr.size()); n_fail++;
        end
        n_cmp++;
        for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
            if (log_addr[i] !== 16'h0010 + 16'(4*i) || log_wdata[i] !== 32'hA0 + 32'(i) ||
                log_we[i] !== 1'b1 || log_strb[i] !== 4'hF) begin
                $display("FAIL wr_beat%0d: got a=%h d=%h we=%b s=%h want a=%h d=%h we=1 s=f", i,
                         log_addr[i], log_wdata[i], log_we[i], log_strb[i],
                         16'h0010 + 16'(4*i), 32'hA0 + 32'(i)); n_fail++;
            end
            n_cmp++;
        end
        if (d_err !== 1'b0 || d_cnt !== 9'd4) begin
            $display("FAIL wr_status: got err=%b cnt=%0d want err=0 cnt=4", d_err, d_cnt); n_fail++;
        end
        n_cmp++;
        if (done_cyc - acc_cyc - 1 != 12) begin
            $display("FAIL wr_latency: got %0d want 12", done_cyc - acc_cyc - 1); n_fail++;
        end
        n_cmp++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL wr_idle_after: got rdy=%b busy=%b want 1/0", cmd_ready, busy); n_fail++;
        end
        n_cmp++;
    endtask

    task automatic test_read_stall();
        int k;
        clear_logs();
        rd_base = 32'h11; rd_step = 32'h11; wait_n = 0; rd_ready = 1'b0;
        issue(1'b0, 16'h0100, 8'd1, 4'h3);
        k = 0;
        while (rd_valid !== 1'b1 && k < 20) begin
            @(negedge clk); k++;
        end
        if (rd_valid !== 1'b1) begin
            $display("FAIL rd_valid_timeout: got rd_valid=%b want 1", rd_valid); n_fail++;
        end
        n_cmp++;
        for (int i = 0; i < 5; i++) begin
            if (rd_data !== 32'h11 || p_sel !== 1'b0) begin
                $display("FAIL rd_stall%0d: got data=%h sel=%b want 11/0", i, rd_data, p_sel); n_fail++;
            end
            n_cmp++;
            @(negedge clk);
        end
        rd_ready = 1'b1;
        wait_done("rd", 100);
        if (rd_log.size() !== 2 || rd_log[0] !== 32'h11 || rd_log[1] !== 32'h22) begin
            $display("FAIL rd_stream: got n=%0d want 2 beats 11,22", rd_log.size()); n_fail++;
        end
        n_cmp++;
        if (log_addr.size() !== 2 || log_addr[0] !== 16'h0100 || log_addr[1] !== 16'h0104 ||
            log_we[0] !== 1'b0 || log_strb[0] !== 4'hF || log_strb[1] !== 4'hF) begin
            $display("FAIL rd_apb: got n=%0d want reads at 0100/0104 strb f", log_addr.size()); n_fail++;
        end
        n_cmp++;
        if (d_err !== 1'b0 || d_cnt !== 9'd2 || sel_stall != 0 || unstable != 0) begin
            $display("FAIL rd_status: got err=%b cnt=%0d sel=%0d unst=%0d want 0/2/0/0",
                     d_err, d_cnt, sel_stall, unstable); n_fail++;
        end
        n_cmp++;
    endtask

    task automatic test_timeout();
        clear_logs();
        rd_base = 32'h5000; rd_step = 32'h1; wait_n = 0; hang_beat = 1; rd_ready = 1'b1;
        issue(1'b0, 16'h0200, 8'd2, 4'hF);
        wait_done("to", 100);
        hang_beat = -1;
        if (d_err !== 1'b1 || d_cnt !== 9'd1) begin
            $display("FAIL to_status: got err=%b cnt=%0d want err=1 cnt=1", d_err, d_cnt); n_fail++;
        end
        n_cmp++;
        if (last_run != 16) begin
            $display("FAIL to_access_len: got %0d want 16", last_run); n_fail++;
        end
        n_cmp++;
        if (setup_cnt != 2 || rd_log.size() != 1) begin
            $display("FAIL to_abandon: got setups=%0d rd=%0d want 2/1", setup_cnt, rd_log.size()); n_fail++;
        end
        n_cmp++;
    endtask

    task automatic test_addr_wrap();
        clear_logs();
        wait_n = 0; rd_ready = 1'b1;
        issue(1'b0, 16'hFFFC, 8'd1, 4'hF);
        wait_done("wrap", 100);
        if (log_addr.size() !== 2 || log_addr[0] !== 16'hFFFC || log_addr[1] !== 16'h0000) begin
            $display("FAIL wrap_inc: got n=%0d want FFFC,0000", log_addr.size()); n_fail++;
        end
        n_cmp++;
        if (log_addr1.size() !== 2 || log_addr1[0] !== 16'hFFFC || log_addr1[1] !== 16'hFFFC) begin
            $display("FAIL wrap_fixed: got n=%0d want FFFC,FFFC", log_addr1.size()); n_fail++;
        end
        n_cmp++;
    endtask

    task automatic test_async_reset();
        int k, d0;
        clear_logs();
        wd_tab[0] = 32'h1111; wd_tab[1] = 32'h2222; wd_tab[2] = 32'h3333; wd_tab[3] = 32'h4444;
        wd_idx = 0; wait_n = 5; wd_en = 1'b1;
        issue(1'b1, 16'h0300, 8'd3, 4'hF);
        k = 0;
        while (p_ce !== 1'b1 && k < 20) begin
            @(negedge clk); k++;
        end
        d0 = done_seen;
        #2 rst_n = 1'b0;
        #1;
        if (p_sel !== 1'b0 || p_ce !== 1'b0 || k >= 20) begin
            $display("FAIL arst_apb_drop: got sel=%b ce=%b k=%0d want 0/0", p_sel, p_ce, k); n_fail++;
        end
        n_cmp++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        if (cmd_ready !== 1'b1 || done_seen != d0 || busy !== 1'b0) begin
            $display("FAIL arst_recover: got rdy=%b dones=%0d busy=%b want 1/%0d/0",
                     cmd_ready, done_seen, busy, d0); n_fail++;
        end
        n_cmp++;
        clear_logs();
        wd_tab[0] = 32'h5555AAAA; wd_idx = 0; wait_n = 0;
        issue(1'b1, 16'h0040, 8'd0, 4'h5);
        wait_done("arst_new", 100);
        wd_en = 1'b0;
        if (log_addr.size() !== 1 || log_addr[0] !== 16'h0040 || log_wdata[0] !== 32'h5555AAAA ||
            log_strb[0] !== 4'h5) begin
            $display("FAIL arst_new_beat: got n=%0d want one write 0040=5555aaaa strb 5",
                     log_addr.size()); n_fail++;
        end
        n_cmp++;
        if (d_err !== 1'b0 || d_cnt !== 9'd1) begin
            $display("FAIL arst_new_status: got err=%b cnt=%0d want 0/1", d_err, d_cnt); n_fail++;
        end
        n_cmp++;
    endtask

    task automatic test_coincide_long();
        int bad;
        clear_logs();
        rd_base = 32'hC000_0000; rd_step = 32'h1; wait_n = 15; rd_ready = 1'b1;
        issue(1'b0, 16'h1000, 8'd255, 4'hF);
        wait_done("long", 6000);
        if (d_err !== 1'b0 || d_cnt !== 9'd256) begin
            $display("FAIL long_status: got err=%b cnt=%0d want 0/256", d_err, d_cnt); n_fail++;
        end
        n_cmp++;
        if (last_run != 16) begin
            $display("FAIL long_coincide: got access run %0d want 16", last_run); n_fail++;
        end
        n_cmp++;
        bad = 0;
        if (rd_log.size() != 256 || log_addr.size() != 256) bad = 1000;
        else begin
            for (int i = 0; i < 256; i++) begin
                if (rd_log[i] !== 32'hC000_0000 + 32'(i)) bad++;
                if (log_addr[i] !== 16'h1000 + 16'(4*i)) bad++;
            end
        end
        if (bad != 0) begin
            $display("FAIL long_data: got %0d bad entries (n=%0d) want 0", bad, rd_log.size()); n_fail++;
        end
        n_cmp++;
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_read_stall();
        test_timeout();
        test_addr_wrap();
        test_async_reset();
        test_coincide_long();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
